// File: rtl/yd_pkg.sv
// yd_pkg -- shared constants and types for the yd instruction-fetch slice.
//   YD_IW / YD_AW : instruction and address widths (16 bits each)
//   YD_NOP        : bubble instruction presented when nothing is valid
//   YD_RST_PC     : default fetch address after reset
//   yd_entry_t    : one instruction-queue entry, {pc, inst}
package yd_pkg;

    localparam int YD_IW = 16;
    localparam int YD_AW = 16;

    localparam logic [YD_IW-1:0] YD_NOP    = 16'h0000;
    localparam logic [YD_AW-1:0] YD_RST_PC = 16'h0000;

    typedef struct packed {
        logic [YD_AW-1:0] pc;
        logic [YD_IW-1:0] inst;
    } yd_entry_t;

endpackage

// File: rtl/yd_ififo.sv
// yd_ififo -- instruction queue storage for yd_ifetch.
//   DEPTH entries of yd_entry_t (32 bits), DEPTH a power of two.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the queue; a same-cycle push or pop is ignored
//   push       : write push_data at the tail
//   push_data  : {pc, inst} entry to store
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (content undefined when empty)
//   empty      : queue holds no entries
//   count      : number of entries held, $clog2(DEPTH)+1 bits
module yd_ififo
    import yd_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  yd_entry_t     push_data,
    input  logic          pop,
    output yd_entry_t     head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    yd_entry_t     slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push && !flush && (count != CW'(DEPTH));
    assign do_pop  = pop && !flush && !empty;
    assign head    = slots[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/yd_ifetch.sv
// yd_ifetch -- sequential instruction prefetcher with redirect support.
// Issues in-order reads from fetch_pc, keeps returned instructions in a
// DEPTH-entry queue (yd_ififo) and presents the head to the core.
// Requests are credit-limited so queued + in-flight never exceeds DEPTH;
// after a redirect, responses still in flight are counted out and dropped.
// Parameters:
//   DEPTH  : queue entries, power of two, 2..8
//   RST_PC : fetch address after reset
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   redirect, redirect_pc  : one-cycle jump request and its target
//   inst_out, inst_pc      : head instruction and its address (0 when invalid)
//   inst_valid, inst_ready : head valid / core consumes head
//   m_req, m_addr, m_gnt   : memory read request, address, accept
//   m_rvalid, m_rdata      : in-order read response
// Configuration macro:
//   YD_IFETCH_BYPASS_EN : when defined, a response arriving to an empty
//                         queue is presented on inst_out in the same cycle
//                         and is only queued if the core does not take it.
module yd_ifetch
    import yd_pkg::*;
#(
    parameter int               DEPTH  = 4,
    parameter logic [YD_AW-1:0] RST_PC = YD_RST_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [YD_AW-1:0] redirect_pc,
    output logic [YD_IW-1:0] inst_out,
    output logic [YD_AW-1:0] inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic             m_req,
    output logic [YD_AW-1:0] m_addr,
    input  logic             m_gnt,
    input  logic             m_rvalid,
    input  logic [YD_IW-1:0] m_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Credit sum is computed one bit wider so it can never wrap.
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    logic [YD_AW-1:0] fetch_pc;
    logic [YD_AW-1:0] resp_pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    discard;

    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    yd_entry_t        fifo_head;
    yd_entry_t        push_data;

    logic             issue;
    logic             rsp_ok;
    logic             rsp_keep;
    logic             bypass_hit;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign m_req  = !rst && !redirect &&
                    (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_X);
    assign m_addr = fetch_pc;
    assign issue  = m_req && m_gnt;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // A response with nothing outstanding is a protocol error and ignored.
    assign rsp_ok   = !rst && m_rvalid && (outstanding != '0);
    // Responses in a redirect cycle or still owed to discard are dropped.
    assign rsp_keep = rsp_ok && !redirect && (discard == '0);

`ifdef YD_IFETCH_BYPASS_EN
    assign bypass_hit = rsp_keep && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed instruction taken by the core never enters the queue.
    assign push = rsp_keep && !(bypass_hit && inst_ready);
    assign pop  = !rst && !redirect && !fifo_empty && inst_ready;

    always_comb begin
        push_data      = '0;
        push_data.pc   = resp_pc;
        push_data.inst = m_rdata;
    end

    yd_ififo #(
        .DEPTH (DEPTH)
    ) u_ififo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Core-facing outputs: bubble whenever nothing is valid.
    // ------------------------------------------------------------------
    always_comb begin
        inst_valid = 1'b0;
        inst_out   = YD_NOP;
        inst_pc    = '0;
        if (!rst) begin
            if (!fifo_empty) begin
                inst_valid = 1'b1;
                inst_out   = fifo_head.inst;
                inst_pc    = fifo_head.pc;
            end else if (bypass_hit) begin
                inst_valid = 1'b1;
                inst_out   = m_rdata;
                inst_pc    = resp_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // PC, credit and discard bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RST_PC;
            resp_pc     <= RST_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
            if (redirect) begin
                // Everything still in flight after this cycle is stale,
                // whether or not an earlier redirect was still draining.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                discard  <= outstanding - CW'(rsp_ok);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 16'd1;
                end
                if (rsp_ok) begin
                    if (discard != '0) begin
                        discard <= discard - CW'(1);
                    end else begin
                        resp_pc <= resp_pc + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_yd_ifetch.sv
// tb_yd_ifetch -- scoreboard bench for yd_ifetch (DEPTH=4, RST_PC=0).
// Memory model returns mem_f(addr) with a programmable latency; expected
// {pc, inst} pairs are queued by the stimulus and popped by a monitor on
// every accepted instruction.
module tb_yd_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        m_req;
    logic [15:0] m_addr;
    logic        m_gnt;
    logic        m_rvalid;
    logic [15:0] m_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int consumed = 0;
    int pop_log[$];
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] due;
    } rd_t;
    rd_t pend[$];

`ifdef YD_IFETCH_BYPASS_EN
    localparam int BYP_DELAY = 0;
`else
    localparam int BYP_DELAY = 1;
`endif

    yd_ifetch #(
        .DEPTH  (4),
        .RST_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .m_req       (m_req),
        .m_addr      (m_addr),
        .m_gnt       (m_gnt),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory: grants recorded at negedge, responses driven 1 after posedge.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
        end else if (m_req && m_gnt) begin
            pend.push_back('{a: m_addr, due: 32'(cyc + lat)});
        end
    end

    always @(posedge clk) begin
        rd_t r;
        #1;
        if (pend.size() > 0 && int'(pend[0].due) <= cyc) begin
            r        = pend.pop_front();
            m_rvalid = 1'b1;
            m_rdata  = mem_f(r.a);
        end else begin
            m_rvalid = 1'b0;
            m_rdata  = 16'hDEAD;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && !redirect && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inst_unexpected actual=%h required=none",
                         {inst_pc, inst_out});
            end else begin
                e = exp_q.pop_front();
                check("inst", {inst_pc, inst_out}, e);
            end
            consumed++;
            pop_log.push_back(cyc);
        end else if (!rst && !inst_valid) begin
            check("bubble", {inst_pc, inst_out}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(i);
            exp_q.push_back({a, mem_f(a)});
        end
    endtask

    // Called at cycle start; returns at the negedge of the first cycle
    // after reset is released.
    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_m_req", {31'b0, m_req}, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst", {inst_pc, inst_out}, 32'h0);
        tick();
        rst = 1'b0;
        push_seq(16'h0000, 64);
        @(negedge clk);
        check("first_m_req", {31'b0, m_req}, 32'h1);
        check("first_m_addr", {16'h0, m_addr}, 32'h0);
        check("first_inst_valid", {31'b0, inst_valid}, 32'h0);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        exp_q.delete();
        push_seq(pc, 16);
        tick();
        redirect = 1'b0;
    endtask

    task automatic wait_consumed(input int target, input string name);
        int k;
        k = 0;
        while (consumed < target && k < 200) begin
            tick();
            k++;
        end
        if (consumed < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=%0d",
                     name, consumed, target);
        end
    endtask

    initial begin
        int first_rv;
        int first_iv;
        int base;

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        inst_ready  = 1'b1;
        m_gnt       = 1'b1;
        m_rvalid    = 1'b0;
        m_rdata     = 16'h0000;

        // Reset state and response-to-valid latency with a 2-cycle memory.
        lat = 2;
        tick();
        tick();
        do_reset();
        first_rv = -1;
        first_iv = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (first_rv < 0 && m_rvalid)   first_rv = cyc;
            if (first_iv < 0 && inst_valid) first_iv = cyc;
        end
        if (first_rv < 0 || first_iv < 0) begin
            checks++;
            errors++;
            $display("FAIL first_valid_timeout actual=%0d/%0d required=seen",
                     first_rv, first_iv);
        end else begin
            check("bypass_latency", 32'(first_iv - first_rv), 32'(BYP_DELAY));
        end
        tick();
        wait_consumed(8, "lat2_stream");

        // Streaming with a 1-cycle memory: one instruction per cycle.
        lat = 1;
        do_reset();
        tick();
        base = consumed;
        wait_consumed(base + 14, "stream");
        if (pop_log.size() >= base + 14) begin
            check("stream_rate", 32'(pop_log[base + 13] - pop_log[base + 3]),
                  32'd10);
        end

        // Backpressure: credit must stop requests, order must survive.
        inst_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("bp_m_req", {31'b0, m_req}, 32'h0);
        check("bp_inst_valid", {31'b0, inst_valid}, 32'h1);
        tick();
        inst_ready = 1'b1;
        base = consumed;
        wait_consumed(base + 10, "bp_resume");

        // Redirect with two reads in flight on a 2-cycle memory.
        lat = 2;
        repeat (6) tick();
        redirect_to(16'h0100);
        base = consumed;
        wait_consumed(base + 6, "redirect");

        // Address wrap.
        lat = 1;
        redirect_to(16'hFFFE);
        base = consumed;
        wait_consumed(base + 6, "wrap");

        // Reset with three reads outstanding on a 4-cycle memory.
        lat = 4;
        redirect_to(16'h0200);
        repeat (3) tick();
        do_reset();
        tick();
        base = consumed;
        wait_consumed(base + 6, "rst_restart");

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/yd_ifetch.md
YD_IFETCH -- requirements
Module: yd_ifetch

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DEPTH, 4, instruction queue entries; power of two, 2..8.
- RST_PC, 16'h0000, fetch address after reset.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset.
- redirect  in  1  core jump, one-cycle pulse.
- redirect_pc  in  16  jump target.
- inst_out  out  16  instruction to core.
- inst_pc  out  16  address of inst_out.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  core consumes head.
- m_req  out  1  memory read request.
- m_addr  out  16  memory read address.
- m_gnt  in  1  memory accepts the request this cycle.
- m_rvalid  in  1  read data returned; in request order, latency at least 1.
- m_rdata  in  16  read data.

REQ-003 Reset SHALL be rst, synchronous, active-high; clock SHALL be clk.

Function
REQ-004 SHALL prefetch sequential instructions from fetch_pc into a DEPTH-entry FIFO holding {pc, data} pairs.
REQ-005 m_req SHALL be 1 only when all of the following hold: rst=0, redirect=0, and fifo_count+outstanding < DEPTH (credit rule).
REQ-006 m_addr SHALL equal fetch_pc.
REQ-007 On m_req&m_gnt: fetch_pc increments by 1 and wraps from 16'hFFFF to 16'h0000; outstanding increments.
REQ-008 On m_rvalid: outstanding decrements.
- If discard>0: discard decrements and the data is dropped.
- Otherwise {addr, m_rdata} is pushed, with addr tracked by an in-order response address counter.
REQ-009 inst_valid SHALL equal FIFO not empty. Head is popped on inst_valid&inst_ready.
REQ-010 When inst_valid=0: inst_out SHALL be 16'h0000 (bubble), inst_pc SHALL be 16'h0000.
REQ-011 On redirect, in the same cycle, the block SHALL:
- empty the FIFO (a same-cycle pop is ignored);
- set fetch_pc and the response address counter to redirect_pc;
- set discard to outstanding minus m_rvalid.
REQ-012 A response arriving in the redirect cycle SHALL be dropped.
REQ-013 Redirect while discard>0 SHALL load discard with total in-flight count; no stale data ever reaches inst_out.
REQ-014 Simultaneous push and pop SHALL keep fifo_count unchanged. The credit rule guarantees no push when full. An m_rvalid with outstanding=0 is a protocol error; the block SHALL ignore it.
REQ-015 Counters SHALL be $clog2(DEPTH)+1 bits; outstanding+fifo_count never exceeds DEPTH.

Reset
REQ-016 On rst: fetch_pc=RST_PC, FIFO empty, outstanding=0, discard=0, m_req=0, inst_valid=0, inst_out=16'h0000, inst_pc=16'h0000.
REQ-017 A reset asserted mid-transaction SHALL abandon in-flight reads. Memory is reset by the same rst, so no late responses are expected.
REQ-018 The first m_req SHALL be issued in the first cycle after rst deasserts.

Configuration
REQ-019 Macro YD_IFETCH_BYPASS_EN:
- Defined: when the FIFO is empty, discard=0 and m_rvalid=1, m_rdata appears on inst_out with inst_valid=1 in the same cycle. It is pushed only if inst_ready=0.
- Undefined: all data passes through the FIFO, giving one extra cycle of latency.

Structure
REQ-020 Shared package yd_pkg SHALL hold YD_NOP (16'h0000), YD_RST_PC, and the instruction and address width constants (16).
REQ-021 FIFO storage and pointers SHALL be sub-module yd_ififo (DEPTH x 32 bits, flush input, count output). Credit, discard and PC logic stay in yd_ifetch.

Verification
REQ-022 Streaming:
- Stimulus: memory with 1-cycle latency, m_gnt=1, inst_ready=1, RST_PC=0.
- Required: inst_pc sequence 0,1,2,3,... with inst_out=mem[pc]; one instruction per cycle after the pipeline fills.
REQ-023 Backpressure:
- Stimulus: inst_ready=0 for 10 cycles.
- Required: m_req drops once fifo_count+outstanding=4; no overflow; resume yields contiguous pc order.
REQ-024 Redirect:
- Stimulus: redirect to 16'h0100 with 2 reads outstanding.
- Required: both stale responses dropped; next inst_valid shows inst_pc=16'h0100, inst_out=mem[0x100].
REQ-025 Wrap:
- Stimulus: redirect to 16'hFFFE.
- Required: inst_pc sequence FFFE, FFFF, 0000, 0001.
REQ-026 Reset mid-fetch:
- Stimulus: rst for 1 cycle with 3 outstanding reads.
- Required: all outputs at reset values next cycle; fetch restarts at RST_PC.
REQ-027 Bypass:
- With YD_IFETCH_BYPASS_EN and latency-2 memory: inst_valid in the same cycle as the first m_rvalid.
- Without the macro: one cycle later.
